// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge frequency meter with saturating count
module freq_meter #(
    parameter int GATE_LOG2 = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [GATE_LOG2-1:0] GATE_ONE = 1;

    state_t                 state;
    state_t                 state_nxt;
    logic                   s1;
    logic                   s2;
    logic                   s3;
    logic                   edge_now;
    logic [GATE_LOG2-1:0]   gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   sat;
    logic                   last_cycle;
    logic [CNT_W:0]         sum;
    logic                   sum_sat;
    logic [CNT_W-1:0]       closing_count;

    // Synchronizer plus delay flop; runs in every state so a pre-entry edge is consumed once
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_now   = s2 & ~s3;
    assign last_cycle = (state == MEASURE) && (gate_cnt == '1);

    // One extra bit catches the carry out of an already-full counter
    assign sum           = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, edge_now};
    assign sum_sat       = sum[CNT_W];
    assign closing_count = sum_sat ? '1 : sum[CNT_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: en alone decides; a closing window still completes in the datapath
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en ? MEASURE : IDLE;
            MEASURE: state_nxt = en ? MEASURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == MEASURE);
    end

    // Gate timer, edge accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            sat         <= 1'b0;
            freq_count  <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (state == MEASURE) begin
                gate_cnt <= gate_cnt + GATE_ONE;
                if (last_cycle) begin
                    // Final-cycle edge belongs to the closing window only
                    freq_count  <= closing_count;
                    overflow    <= sat | sum_sat;
                    count_valid <= 1'b1;
                    edge_cnt    <= '0;
                    sat         <= 1'b0;
                end else if (sum_sat) begin
                    sat <= 1'b1;
                end else begin
                    edge_cnt <= sum[CNT_W-1:0];
                end
            end else begin
                // Idle keeps counters cleared so every entry starts a fresh window
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sig_in;
    logic [31:0] freq_count;
    logic        count_valid;
    logic        overflow;
    logic        busy;
    logic [2:0]  freq_count3;
    logic        count_valid3;
    logic        overflow3;
    logic        busy3;

    logic        tog;
    int          n_pass;
    int          n_total;
    int          n;
    int          pulses;

    freq_meter #(.GATE_LOG2(4), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sig_in      (sig_in),
        .freq_count  (freq_count),
        .count_valid (count_valid),
        .overflow    (overflow),
        .busy        (busy)
    );

    freq_meter #(.GATE_LOG2(4), .CNT_W(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sig_in      (sig_in),
        .freq_count  (freq_count3),
        .count_valid (count_valid3),
        .overflow    (overflow3),
        .busy        (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) sig_in = ~sig_in;
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cycles++;
            if (count_valid) break;
        end
        check({tag, "_seen"}, {31'd0, count_valid}, 32'd1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        en      = 1'b1;
        sig_in  = 1'b0;
        tog     = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_outs", {freq_count[29:0], count_valid, overflow} | {31'd0, busy}, 32'd0);
            check("reset_outs3", {26'd0, freq_count3, count_valid3, overflow3, busy3}, 32'd0);
        end

        rst = 1'b0;
        step();
        check("entry_busy", {31'd0, busy}, 32'd1);

        wait_valid("w1", n);
        wait_valid("w2", n);
        check("toggle_period", n, 32'd16);
        check("toggle_count", freq_count, 32'd8);
        check("toggle_ovf", {31'd0, overflow}, 32'd0);
        check("sat_count", {29'd0, freq_count3}, 32'd7);
        check("sat_ovf", {31'd0, overflow3}, 32'd1);
        step();
        check("valid_width", {31'd0, count_valid}, 32'd0);
        wait_valid("w3", n);
        check("toggle_period2", n, 32'd15);
        check("toggle_count2", freq_count, 32'd8);
        check("sat_ovf2", {31'd0, overflow3}, 32'd1);

        tog    = 1'b0;
        sig_in = 1'b0;
        wait_valid("z1", n);
        wait_valid("z2", n);
        check("zero_period", n, 32'd16);
        check("zero_count", freq_count, 32'd0);
        check("zero_ovf3", {31'd0, overflow3}, 32'd0);
        check("zero_count3", {29'd0, freq_count3}, 32'd0);
        wait_valid("z3", n);
        check("zero_period2", n, 32'd16);
        check("zero_count2", freq_count, 32'd0);

        tog = 1'b1;
        wait_valid("t1", n);
        wait_valid("t2", n);
        check("pre_abort_count", freq_count, 32'd8);
        for (int i = 0; i < 7; i++) step();
        en = 1'b0;
        step();
        check("abort_busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (count_valid) pulses++;
        end
        check("abort_no_valid", pulses, 32'd0);
        check("abort_hold", freq_count, 32'd8);

        en = 1'b1;
        step();
        check("reentry_busy", {31'd0, busy}, 32'd1);
        wait_valid("r1", n);
        check("reentry_latency", n, 32'd16);
        check("reentry_count", freq_count, 32'd8);

        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        check("midrst_count", freq_count, 32'd0);
        check("midrst_ovf", {31'd0, overflow}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, count_valid}, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_valid("p1", n);
        check("post_rst_latency", n, 32'd16);
        check("post_rst_count", freq_count, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
